// File: rtl/cvxif_complex_pipe.sv
`default_nettype none
// cvxif_complex_pipe: CVXIF complex add/sub/conj/mul coprocessor with in-order result FIFO (rev 1.0).
// Define CVXIF_COMPLEX_MUL_EN to build the multiply path (funct3 011, states MUL1/MUL2).
module cvxif_complex_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2,
   parameter int ID_W  = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            issue_valid,
   output logic            issue_ready,
   input  logic [31:0]     issue_req_instr,
   input  logic [ID_W-1:0] issue_req_id,
   output logic            issue_resp_accept,
   output logic            issue_resp_writeback,
   output logic [1:0]      issue_resp_register_read,
   input  logic            register_valid,
   output logic            register_ready,
   input  logic [ID_W-1:0] register_id,
   input  logic [XLEN-1:0] register_rs0,
   input  logic [XLEN-1:0] register_rs1,
   input  logic [1:0]      register_rs_valid,
   output logic            result_valid,
   input  logic            result_ready,
   output logic [XLEN-1:0] result_data,
   output logic [ID_W-1:0] result_id
);
   localparam int HALF  = XLEN / 2;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ENT_W = XLEN + ID_W;
   localparam logic [2:0]  F3_ADD     = 3'b000;
   localparam logic [2:0]  F3_CONJ    = 3'b001;
   localparam logic [2:0]  F3_SUB     = 3'b010;
   localparam logic [31:0] MATCH_MASK = 32'hFE00_007F;
   localparam logic [31:0] MATCH_VAL  = 32'h0000_007B;

`ifdef CVXIF_COMPLEX_MUL_EN
   localparam logic [2:0] F3_MUL = 3'b011;
   typedef enum logic [1:0] {IDLE, WAITREGS, MUL1, MUL2} state_t;
`else
   typedef enum logic [0:0] {IDLE, WAITREGS} state_t;
`endif

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic              issue_ready_q, issue_ready_d;
   logic [ENT_W-1:0]  mem_q [DEPTH];
   logic [ENT_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [2:0]        f3;
   logic              f3_ok, insn_match, xfer, push, pop;
   logic [XLEN-1:0]   push_data, alu_res;
   logic [HALF-1:0]   a_re, a_im, b_re, b_im;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign f3 = issue_req_instr[14:12];
`ifdef CVXIF_COMPLEX_MUL_EN
   assign f3_ok = (f3 == F3_ADD) || (f3 == F3_CONJ) || (f3 == F3_SUB) || (f3 == F3_MUL);
`else
   assign f3_ok = (f3 == F3_ADD) || (f3 == F3_CONJ) || (f3 == F3_SUB);
`endif
   assign insn_match = ((issue_req_instr & MATCH_MASK) == MATCH_VAL) && f3_ok;

   // issue_ready_q is only ever set while the next state is IDLE with a free FIFO slot
   assign issue_ready              = issue_ready_q;
   assign issue_resp_accept        = issue_valid && issue_ready_q && insn_match;
   assign issue_resp_writeback     = 1'b1;
   assign issue_resp_register_read = issue_resp_accept ? ((f3 == F3_CONJ) ? 2'b01 : 2'b11) : 2'b00;
   assign register_ready           = (state_q == WAITREGS) && (register_id == id_q);
   assign xfer = register_valid && register_ready && register_rs_valid[0] &&
                 (register_rs_valid[1] || (op_q == F3_CONJ));

   assign a_re = register_rs0[XLEN-1:HALF];
   assign a_im = register_rs0[HALF-1:0];
   assign b_re = register_rs1[XLEN-1:HALF];
   assign b_im = register_rs1[HALF-1:0];

   always_comb begin
      case (op_q)
         F3_ADD:  alu_res = {a_re + b_re, a_im + b_im};
         F3_SUB:  alu_res = {a_re - b_re, a_im - b_im};
         default: alu_res = {a_re, HALF'(0) - a_im};
      endcase
   end

`ifdef CVXIF_COMPLEX_MUL_EN
   logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d;
   logic [HALF-1:0] re_q, re_d, m0b, m1b, prod0, prod1;
   // MUL1 pairs re*re / im*im, MUL2 pairs re*im / im*re on the same two multipliers
   assign m0b   = (state_q == MUL2) ? opb_q[HALF-1:0] : opb_q[XLEN-1:HALF];
   assign m1b   = (state_q == MUL2) ? opb_q[XLEN-1:HALF] : opb_q[HALF-1:0];
   assign prod0 = opa_q[XLEN-1:HALF] * m0b;
   assign prod1 = opa_q[HALF-1:0] * m1b;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      id_d      = id_q;
      push      = 1'b0;
      push_data = '0;
`ifdef CVXIF_COMPLEX_MUL_EN
      opa_d = opa_q;
      opb_d = opb_q;
      re_d  = re_q;
`endif
      case (state_q)
         IDLE: begin
            if (issue_resp_accept) begin
               op_d    = f3;
               id_d    = issue_req_id;
               state_d = WAITREGS;
            end
         end
         WAITREGS: begin
            if (xfer) begin
`ifdef CVXIF_COMPLEX_MUL_EN
               if (op_q == F3_MUL) begin
                  opa_d   = register_rs0;
                  opb_d   = register_rs1;
                  state_d = MUL1;
               end else
`endif
               begin
                  push      = 1'b1;
                  push_data = alu_res;
                  state_d   = IDLE;
               end
            end
         end
`ifdef CVXIF_COMPLEX_MUL_EN
         MUL1: begin
            re_d    = prod0 - prod1;
            state_d = MUL2;
         end
         MUL2: begin
            push      = 1'b1;
            push_data = {re_q, prod0 + prod1};
            state_d   = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   assign pop          = result_valid && result_ready;
   assign result_valid = (count_q != '0);
   assign {result_data, result_id} = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = {push_data, id_q};
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      issue_ready_d = (state_d == IDLE) && (count_d < CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         op_q          <= '0;
         id_q          <= '0;
         issue_ready_q <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
`ifdef CVXIF_COMPLEX_MUL_EN
         opa_q <= '0;
         opb_q <= '0;
         re_q  <= '0;
`endif
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         id_q          <= id_d;
         issue_ready_q <= issue_ready_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         mem_q         <= mem_d;
`ifdef CVXIF_COMPLEX_MUL_EN
         opa_q <= opa_d;
         opb_q <= opb_d;
         re_q  <= re_d;
`endif
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_cvxif_complex_pipe.sv
`default_nettype none
// tb_cvxif_complex_pipe: directed and randomized checks of cvxif_complex_pipe against a
// behavioural complex-arithmetic model and an in-order result scoreboard.
module tb_cvxif_complex_pipe;
   localparam int XLEN = 32, DEPTH = 2, ID_W = 3;
`ifdef CVXIF_COMPLEX_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic clk = 1'b0, rst_n = 1'b0;
   logic issue_valid = 1'b0, issue_ready, issue_resp_accept, issue_resp_writeback;
   logic [31:0] issue_req_instr = '0;
   logic [2:0]  issue_req_id = '0;
   logic [1:0]  issue_resp_register_read;
   logic        register_valid = 1'b0, register_ready;
   logic [2:0]  register_id = '0;
   logic [31:0] register_rs0 = '0, register_rs1 = '0;
   logic [1:0]  register_rs_valid = '0;
   logic        result_valid, result_ready = 1'b0;
   logic [31:0] result_data;
   logic [2:0]  result_id;

   int checks = 0, errors = 0;
   logic [34:0] sb[$];

   always #5 clk = ~clk;

   cvxif_complex_pipe #(.XLEN(XLEN), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_req_instr(issue_req_instr), .issue_req_id(issue_req_id),
      .issue_resp_accept(issue_resp_accept), .issue_resp_writeback(issue_resp_writeback),
      .issue_resp_register_read(issue_resp_register_read),
      .register_valid(register_valid), .register_ready(register_ready),
      .register_id(register_id), .register_rs0(register_rs0), .register_rs1(register_rs1),
      .register_rs_valid(register_rs_valid),
      .result_valid(result_valid), .result_ready(result_ready),
      .result_data(result_data), .result_id(result_id)
   );

   // Reference: per-component arithmetic on integers, keeping the low 16 bits of each part.
   function automatic logic [31:0] ref_cplx(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint ar = longint'(a[31:16]), ai = longint'(a[15:0]);
      longint br = longint'(b[31:16]), bi = longint'(b[15:0]);
      longint re, im;
      case (op)
         3'd0:    begin re = ar + br; im = ai + bi; end
         3'd2:    begin re = ar - br; im = ai - bi; end
         3'd1:    begin re = ar;      im = -ai;     end
         default: begin re = ar * br - ai * bi; im = ar * bi + ai * br; end
      endcase
      return {re[15:0], im[15:0]};
   endfunction

   function automatic bit ref_match(input logic [31:0] w);
      return (w[6:0] == 7'b1111011) && (w[31:25] == 7'd0) &&
             ((w[14:12] <= 3'd2) || ((w[14:12] == 3'd3) && MUL_ON));
   endfunction

   function automatic logic [31:0] mk_instr(input logic [2:0] op, input logic [6:0] f7);
      logic [14:0] regs = 15'($urandom);
      return {f7, regs[14:5], op, regs[4:0], 7'b1111011};
   endfunction

   task automatic drv_issue(input logic [31:0] w, input logic [2:0] id,
                            output logic acc, output logic [1:0] rr, output bit to);
      int n = 0;
      @(negedge clk);
      issue_valid = 1'b1; issue_req_instr = w; issue_req_id = id;
      #1;
      while (!issue_ready && n < 100) begin @(negedge clk); #1; n++; end
      to = !issue_ready; acc = issue_resp_accept; rr = issue_resp_register_read;
      @(posedge clk); #1;
      issue_valid = 1'b0;
   endtask

   task automatic drv_regs(input logic [2:0] id, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rsv, output logic rdy);
      register_valid = 1'b1; register_id = id; register_rs0 = a; register_rs1 = b; register_rs_valid = rsv;
      #1 rdy = register_ready;
      @(posedge clk); #1;
      register_valid = 1'b0;
   endtask

   task automatic drv_pop(output logic v, output logic [31:0] d, output logic [2:0] id);
      v = result_valid; d = result_data; id = result_id;
      result_ready = 1'b1;
      @(posedge clk); #1;
      result_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; issue_valid = 1'b1; issue_req_instr = mk_instr(3'd0, 7'd0);
      register_valid = 1'b1; register_rs_valid = 2'b11;
      repeat (2) @(posedge clk); #1;
      checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_issue_ready: got %b want 0", issue_ready); end
      checks++; if (issue_resp_accept !== 1'b0) begin errors++; $display("FAIL rst_accept: got %b want 0", issue_resp_accept); end
      checks++; if (issue_resp_register_read !== 2'b00) begin errors++; $display("FAIL rst_rr: got %b want 00", issue_resp_register_read); end
      checks++; if (register_ready !== 1'b0) begin errors++; $display("FAIL rst_reg_ready: got %b want 0", register_ready); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_result_valid: got %b want 0", result_valid); end
      checks++; if (result_data !== 32'h0) begin errors++; $display("FAIL rst_result_data: got %h want 0", result_data); end
      checks++; if (result_id !== 3'd0) begin errors++; $display("FAIL rst_result_id: got %0d want 0", result_id); end
      @(negedge clk); rst_n = 1'b1; issue_valid = 1'b0; register_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_rst_issue_ready: got %b want 1", issue_ready); end
      checks++; if (issue_resp_writeback !== 1'b1) begin errors++; $display("FAIL writeback: got %b want 1", issue_resp_writeback); end
   endtask

   task automatic test_add;
      logic acc, rdy, v; logic [1:0] rr; bit to; logic [31:0] d; logic [2:0] id;
      drv_issue(mk_instr(3'd0, 7'd0), 3'd5, acc, rr, to);
      checks++; if (to || acc !== 1'b1) begin errors++; $display("FAIL add_accept: got %b (timeout %0d) want 1", acc, to); end
      checks++; if (rr !== 2'b11) begin errors++; $display("FAIL add_rr: got %b want 11", rr); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid: got %b want 0", result_valid); end
      drv_regs(3'd5, 32'h0003_0004, 32'h0001_FFFF, 2'b11, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL add_reg_ready: got %b want 1", rdy); end
      checks++; if (result_valid !== 1'b1) begin errors++; $display("FAIL add_valid_r1: got %b want 1", result_valid); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL add_next_issue: got %b want 1", issue_ready); end
      drv_pop(v, d, id);
      checks++; if (d !== 32'h0004_0003) begin errors++; $display("FAIL add_data: got %h want 00040003", d); end
      checks++; if (id !== 3'd5) begin errors++; $display("FAIL add_id: got %0d want 5", id); end
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL add_after_pop: got %b want 0", result_valid); end
   endtask

   task automatic test_conj_reject;
      logic acc, rdy, v; logic [1:0] rr; bit to; logic [31:0] d; logic [2:0] id;
      drv_issue(mk_instr(3'd1, 7'd0), 3'd2, acc, rr, to);
      checks++; if (to || acc !== 1'b1) begin errors++; $display("FAIL conj_accept: got %b want 1", acc); end
      checks++; if (rr !== 2'b01) begin errors++; $display("FAIL conj_rr: got %b want 01", rr); end
      drv_regs(3'd2, 32'h0002_0005, $urandom, 2'b01, rdy);
      drv_pop(v, d, id);
      checks++; if (v !== 1'b1 || d !== 32'h0002_FFFB || id !== 3'd2) begin errors++;
         $display("FAIL conj_result: got v=%b %h id %0d want 1 0002fffb id 2", v, d, id); end
      drv_issue(mk_instr(3'd0, 7'd1), 3'd2, acc, rr, to);
      checks++; if (acc !== 1'b0 || rr !== 2'b00) begin errors++; $display("FAIL reject_f7: got acc %b rr %b want 0 00", acc, rr); end
      register_valid = 1'b1; register_id = 3'd2; #1;
      checks++; if (issue_ready !== 1'b1 || register_ready !== 1'b0) begin errors++;
         $display("FAIL reject_stays_idle: got issue_ready %b reg_ready %b want 1 0", issue_ready, register_ready); end
      register_valid = 1'b0;
   endtask

   task automatic test_sub_wrong_id;
      logic acc, v; logic [1:0] rr; bit to; logic [31:0] d; logic [2:0] id;
      drv_issue(mk_instr(3'd2, 7'd0), 3'd3, acc, rr, to);
      register_valid = 1'b1; register_id = 3'd4; register_rs0 = 32'h0; register_rs1 = 32'h0001_0001;
      register_rs_valid = 2'b11; #1;
      checks++; if (register_ready !== 1'b0) begin errors++; $display("FAIL sub_wrong_id_ready: got %b want 0", register_ready); end
      @(posedge clk); #1;
      register_id = 3'd3; register_rs_valid = 2'b10; #1;
      checks++; if (result_valid !== 1'b0 || issue_ready !== 1'b0 || register_ready !== 1'b1) begin errors++;
         $display("FAIL sub_wrong_id_xfer: got valid %b issue_ready %b reg_ready %b want 0 0 1", result_valid, issue_ready, register_ready); end
      @(posedge clk); #1;
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL sub_partial_rsv: got %b want 0", result_valid); end
      register_rs_valid = 2'b11;
      @(posedge clk); #1;
      register_valid = 1'b0;
      drv_pop(v, d, id);
      checks++; if (v !== 1'b1 || d !== 32'hFFFF_FFFF || id !== 3'd3) begin errors++;
         $display("FAIL sub_result: got v=%b %h id %0d want 1 ffffffff id 3", v, d, id); end
   endtask

   task automatic test_mul;
      logic acc, rdy, v; logic [1:0] rr; bit to; logic [31:0] d; logic [2:0] id;
      drv_issue(mk_instr(3'd3, 7'd0), 3'd7, acc, rr, to);
`ifdef CVXIF_COMPLEX_MUL_EN
      checks++; if (acc !== 1'b1 || rr !== 2'b11) begin errors++; $display("FAIL mul_accept: got %b rr %b want 1 11", acc, rr); end
      drv_regs(3'd7, 32'h0001_0002, 32'h0003_0004, 2'b11, rdy);
      checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mul_valid_r1: got %b want 0", result_valid); end
      @(posedge clk); #1;
      checks++; if (result_valid !== 1'b0 || issue_ready !== 1'b0) begin errors++;
         $display("FAIL mul_r2: got valid %b issue_ready %b want 0 0", result_valid, issue_ready); end
      @(posedge clk); #1;
      checks++; if (result_valid !== 1'b1 || issue_ready !== 1'b1) begin errors++;
         $display("FAIL mul_r3: got valid %b issue_ready %b want 1 1", result_valid, issue_ready); end
      drv_pop(v, d, id);
      checks++; if (d !== 32'hFFFB_000A || id !== 3'd7) begin errors++; $display("FAIL mul_result: got %h id %0d want fffb000a id 7", d, id); end
`else
      checks++; if (acc !== 1'b0 || rr !== 2'b00) begin errors++; $display("FAIL mul_reject: got acc %b rr %b want 0 00", acc, rr); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL mul_reject_idle: got %b want 1", issue_ready); end
`endif
   endtask

   task automatic test_backpressure;
      logic acc, rdy, v; logic [1:0] rr; bit to; logic [31:0] d, a1, b1, a2, b2, d1; logic [2:0] id;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
      drv_issue(mk_instr(3'd0, 7'd0), 3'd1, acc, rr, to);
      drv_regs(3'd1, a1, b1, 2'b11, rdy);
      drv_issue(mk_instr(3'd2, 7'd0), 3'd2, acc, rr, to);
      checks++; if (to || acc !== 1'b1) begin errors++; $display("FAIL bp_second_accept: got %b want 1", acc); end
      drv_regs(3'd2, a2, b2, 2'b11, rdy);
      checks++; if (issue_ready !== 1'b0 || result_id !== 3'd1) begin errors++;
         $display("FAIL bp_full: got issue_ready %b head id %0d want 0 1", issue_ready, result_id); end
      d1 = result_data;
      @(posedge clk); #1;
      checks++; if (result_data !== d1 || result_id !== 3'd1 || result_valid !== 1'b1) begin errors++;
         $display("FAIL bp_hold: got %h id %0d want %h id 1", result_data, result_id, d1); end
      drv_pop(v, d, id);
      checks++; if (d !== ref_cplx(3'd0, a1, b1) || id !== 3'd1) begin errors++;
         $display("FAIL bp_pop1: got %h id %0d want %h id 1", d, id, ref_cplx(3'd0, a1, b1)); end
      checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop: got %b want 1", issue_ready); end
      drv_pop(v, d, id);
      checks++; if (d !== ref_cplx(3'd2, a2, b2) || id !== 3'd2) begin errors++;
         $display("FAIL bp_pop2: got %h id %0d want %h id 2", d, id, ref_cplx(3'd2, a2, b2)); end
   endtask

   task automatic test_reset_midop;
      logic acc, rdy, v; logic [1:0] rr; bit to; logic [31:0] d, a, b; logic [2:0] id;
      drv_issue(mk_instr(3'd0, 7'd0), 3'd4, acc, rr, to);
      drv_regs(3'd4, $urandom, $urandom, 2'b11, rdy);
      drv_issue(mk_instr(3'd0, 7'd0), 3'd6, acc, rr, to);
      register_valid = 1'b1; register_id = 3'd6; register_rs_valid = 2'b11;
      rst_n = 1'b0; #1;
      checks++; if (result_valid !== 1'b0 || register_ready !== 1'b0 || issue_ready !== 1'b0) begin errors++;
         $display("FAIL midrst_outputs: got valid %b reg_ready %b issue_ready %b want 0 0 0", result_valid, register_ready, issue_ready); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1; register_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (result_valid !== 1'b0 || issue_ready !== 1'b1) begin errors++;
         $display("FAIL midrst_after: got valid %b issue_ready %b want 0 1", result_valid, issue_ready); end
      a = $urandom; b = $urandom;
      drv_issue(mk_instr(3'd0, 7'd0), 3'd1, acc, rr, to);
      drv_regs(3'd1, a, b, 2'b11, rdy);
      drv_pop(v, d, id);
      checks++; if (v !== 1'b1 || d !== ref_cplx(3'd0, a, b) || id !== 3'd1) begin errors++;
         $display("FAIL midrst_new_add: got v=%b %h id %0d want 1 %h id 1", v, d, id, ref_cplx(3'd0, a, b)); end
   endtask

   task automatic test_random;
      logic acc, rdy, v; logic [1:0] rr, rsv; bit to, exp_acc; logic [31:0] w, a, b, d;
      logic [2:0] id, op, rid; logic [34:0] e; int n;
      for (int i = 0; i < 40; i++) begin
         w  = ($urandom_range(0, 7) == 0) ? 32'($urandom) : mk_instr(3'($urandom_range(0, 3)), 7'd0);
         id = 3'($urandom);
         exp_acc = ref_match(w);
         drv_issue(w, id, acc, rr, to);
         checks++; if (to || acc !== exp_acc) begin errors++; $display("FAIL rand_accept[%0d]: got %b want %b (instr %h)", i, acc, exp_acc, w); end
         if (exp_acc && acc) begin
            op = w[14:12]; a = $urandom; b = $urandom;
            rsv = (op == 3'd1) ? {1'($urandom), 1'b1} : 2'b11;
            checks++; if (rr !== ((op == 3'd1) ? 2'b01 : 2'b11)) begin errors++; $display("FAIL rand_rr[%0d]: got %b op %0d", i, rr, op); end
            drv_regs(id, a, b, rsv, rdy);
            sb.push_back({ref_cplx(op, a, b), id});
         end
         if (sb.size() >= DEPTH || $urandom_range(0, 2) == 0 || i == 39) begin
            while (sb.size() > 0) begin
               n = 0;
               while (!result_valid && n < 20) begin @(posedge clk); #1; n++; end
               checks++;
               if (!result_valid) begin errors++; $display("FAIL rand_timeout[%0d]: got no result want %0d pending", i, sb.size()); sb.delete(); end
               else begin
                  e = sb.pop_front();
                  drv_pop(v, d, rid);
                  if ({d, rid} !== e) begin errors++; $display("FAIL rand_result[%0d]: got %h id %0d want %h id %0d", i, d, rid, e[34:3], e[2:0]); end
               end
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_conj_reject;
      test_sub_wrong_id;
      test_mul;
      test_backpressure;
      test_reset_midop;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end
endmodule
`default_nettype wire
